// File: rtl/line_priority_encoder_seq.sv
// Sequential 8-to-3 line encoder. The block captures one multi-hot request word
// and then sends the index of each set line over a valid/ready port, one index
// per transfer, starting with the highest line.
module line_priority_encoder_seq #(
  parameter int N_LINES = 8,
  parameter int CODE_W  = 3
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                Enable,
  input  logic                load_valid,
  output logic                load_ready,
  input  logic [N_LINES-1:0]  lines,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [CODE_W-1:0]   code,
  output logic                last,
  output logic [CODE_W:0]     count,
  output logic                none
);

  typedef enum logic [0:0] {IDLE, EMIT} state_t;

  state_t               state_q, state_d;
  logic [N_LINES-1:0]   pend_q, pend_d;
  logic                 none_q, none_d;

  // Number of set bits. This is the number of codes that are still pending.
  function automatic logic [CODE_W:0] popcnt(input logic [N_LINES-1:0] v);
    logic [CODE_W:0] c;
    c = '0;
    for (int i = 0; i < N_LINES; i++)
      c = c + {{CODE_W{1'b0}}, v[i]};
    return c;
  endfunction

  // Index of the highest set bit. The loop scans upward, so the highest set bit
  // is the last one written. An all-zero word gives 0.
  function automatic logic [CODE_W-1:0] hi_idx(input logic [N_LINES-1:0] v);
    logic [CODE_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < N_LINES; i++)
      if (v[i]) idx = CODE_W'(i);
    return idx;
  endfunction

  // The outputs depend only on the registers. load_ready is the exception: it
  // also depends on Enable.
  assign out_valid  = (state_q == EMIT);
  assign load_ready = (state_q == IDLE) && Enable;
  assign count      = popcnt(pend_q);
  assign code       = hi_idx(pend_q);
  assign last       = out_valid && (count == {{CODE_W{1'b0}}, 1'b1});
  assign none       = none_q;

  // Next-state logic. In IDLE the block accepts a word. In EMIT each transfer
  // removes the line that was just sent.
  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    none_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (Enable && load_valid) begin
          if (lines != '0) begin
            pend_d  = lines;
            state_d = EMIT;
          end else begin
            none_d  = 1'b1;
          end
        end
      end
      EMIT: begin
        if (out_ready) begin
          pend_d[code] = 1'b0;
          if (last) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers. Reset also clears pend, so a word that is only partly
  // sent when reset arrives is discarded.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      pend_q  <= '0;
      none_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      none_q  <= none_d;
    end
  end

endmodule

// File: tb/tb_line_priority_encoder_seq.sv
// Testbench for line_priority_encoder_seq. It applies directed per-cycle
// vectors, each with expected outputs, and adds hand-written sequences for
// stall and mid-word reset.
module tb_line_priority_encoder_seq;

  logic       clk = 1'b0;
  logic       reset, Enable, load_valid, out_ready;
  logic [7:0] lines;
  logic       load_ready, out_valid, last, none;
  logic [2:0] code;
  logic [3:0] count;

  int errors = 0;
  int checks = 0;

  line_priority_encoder_seq #(.N_LINES(8), .CODE_W(3)) dut (
    .clk(clk), .reset(reset), .Enable(Enable), .load_valid(load_valid),
    .load_ready(load_ready), .lines(lines), .out_valid(out_valid),
    .out_ready(out_ready), .code(code), .last(last), .count(count), .none(none)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       en;
    logic       lv;
    logic [7:0] ln;
    logic       ordy;
    logic       ov;
    logic [2:0] cd;
    logic       lst;
    logic [3:0] cnt;
    logic       lr;
    logic       nn;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive the inputs and let one rising edge pass. The bench then samples on
  // the following falling edge.
  task automatic step(input logic r, input logic en, input logic lv,
                      input logic [7:0] ln, input logic ordy);
    reset = r; Enable = en; load_valid = lv; lines = ln; out_ready = ordy;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic expect_out(input string tag, input logic ov, input logic [2:0] cd,
                            input logic lst, input logic [3:0] cnt,
                            input logic lr, input logic nn);
    chk({tag, ".out_valid"},  {7'd0, out_valid},  {7'd0, ov});
    chk({tag, ".code"},       {5'd0, code},       {5'd0, cd});
    chk({tag, ".last"},       {7'd0, last},       {7'd0, lst});
    chk({tag, ".count"},      {4'd0, count},      {4'd0, cnt});
    chk({tag, ".load_ready"}, {7'd0, load_ready}, {7'd0, lr});
    chk({tag, ".none"},       {7'd0, none},       {7'd0, nn});
  endtask

  initial begin
    // Each vector holds: en lv lines ordy | ov code last count load_ready none.
    // T1: the word A1 is sent as codes 7, 5, 0.
    vecs.push_back('{1'b1, 1'b1, 8'hA1, 1'b1, 1'b1, 3'd7, 1'b0, 4'd3, 1'b0, 1'b0});
    vecs.push_back('{1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 3'd5, 1'b0, 4'd2, 1'b0, 1'b0});
    vecs.push_back('{1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 3'd0, 1'b1, 4'd1, 1'b0, 1'b0});
    vecs.push_back('{1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 3'd0, 1'b0, 4'd0, 1'b1, 1'b0});
    // T3: a zero word gives a one-cycle none pulse.
    vecs.push_back('{1'b1, 1'b1, 8'h00, 1'b1, 1'b0, 3'd0, 1'b0, 4'd0, 1'b1, 1'b1});
    vecs.push_back('{1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 3'd0, 1'b0, 4'd0, 1'b1, 1'b0});
    // T4: with Enable low, no load is accepted.
    vecs.push_back('{1'b0, 1'b1, 8'hFF, 1'b1, 1'b0, 3'd0, 1'b0, 4'd0, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 8'hFF, 1'b1, 1'b0, 3'd0, 1'b0, 4'd0, 1'b0, 1'b0});
    // T6: a single line 0, stalled for one cycle and then sent.
    vecs.push_back('{1'b1, 1'b1, 8'h01, 1'b0, 1'b1, 3'd0, 1'b1, 4'd1, 1'b0, 1'b0});
    vecs.push_back('{1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 3'd0, 1'b1, 4'd1, 1'b0, 1'b0});
    vecs.push_back('{1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 3'd0, 1'b0, 4'd0, 1'b1, 1'b0});
    // Enable low during EMIT does not stall the codes still to be sent.
    vecs.push_back('{1'b1, 1'b1, 8'h06, 1'b1, 1'b1, 3'd2, 1'b0, 4'd2, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 3'd1, 1'b1, 4'd1, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 3'd0, 1'b0, 4'd0, 1'b0, 1'b0});

    // Reset for two cycles, then check the reset state.
    step(1'b1, 1'b1, 1'b0, 8'h00, 1'b0);
    step(1'b1, 1'b1, 1'b0, 8'h00, 1'b0);
    expect_out("reset", 1'b0, 3'd0, 1'b0, 4'd0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
    expect_out("idle", 1'b0, 3'd0, 1'b0, 4'd0, 1'b1, 1'b0);

    for (int i = 0; i < vecs.size(); i++) begin
      step(1'b0, vecs[i].en, vecs[i].lv, vecs[i].ln, vecs[i].ordy);
      expect_out($sformatf("vec%0d", i), vecs[i].ov, vecs[i].cd, vecs[i].lst,
                 vecs[i].cnt, vecs[i].lr, vecs[i].nn);
    end

    // T2: the consumer stalls for 3 cycles. The block ignores a new load_valid
    // during that time and keeps its outputs unchanged.
    step(1'b0, 1'b1, 1'b1, 8'h84, 1'b0);
    expect_out("t2.load", 1'b1, 3'd7, 1'b0, 4'd2, 1'b0, 1'b0);
    for (int s = 0; s < 3; s++) begin
      step(1'b0, 1'b1, 1'b1, 8'hFF, 1'b0);
      expect_out($sformatf("t2.stall%0d", s), 1'b1, 3'd7, 1'b0, 4'd2, 1'b0, 1'b0);
    end
    step(1'b0, 1'b1, 1'b0, 8'h00, 1'b1);
    expect_out("t2.second", 1'b1, 3'd2, 1'b1, 4'd1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 8'h00, 1'b1);
    expect_out("t2.done", 1'b0, 3'd0, 1'b0, 4'd0, 1'b1, 1'b0);

    // T5: reset arrives after codes 7 and 6 have been sent. The rest of the
    // word is discarded.
    step(1'b0, 1'b1, 1'b1, 8'hFF, 1'b1);
    expect_out("t5.load", 1'b1, 3'd7, 1'b0, 4'd8, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 8'h00, 1'b1);
    expect_out("t5.x1", 1'b1, 3'd6, 1'b0, 4'd7, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 8'h00, 1'b1);
    expect_out("t5.x2", 1'b1, 3'd5, 1'b0, 4'd6, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 8'h00, 1'b1);
    expect_out("t5.reset", 1'b0, 3'd0, 1'b0, 4'd0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b1, 8'h01, 1'b1);
    expect_out("t5.reload", 1'b1, 3'd0, 1'b1, 4'd1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 8'h00, 1'b1);
    expect_out("t5.idle", 1'b0, 3'd0, 1'b0, 4'd0, 1'b1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
